nes_tx_scheduler: RTL and testbench
===================================

# nes_tx_scheduler

Sequences NES button-state frames into `network_stack_tx`. It latches the locally read 8-bit controller state and decides when to send a frame: periodically, on demand, or on a button change. Each frame is a fixed burst of 16-bit payload words, formatted so the receive-side majority vote, which only counts words with high byte equal to low byte, sees only button words. It sits between the local controller reader and the TX network stack, in the `eth_refclk` domain.

## Interface
- `PAYLOAD_WORDS`, 7: words per frame, including the header word; legal range 2..255.
- `PERIOD_CYCLES`, 833_333: periodic send interval in clk cycles (60 Hz at 50 MHz); ≥ 2.
- `GAP_CYCLES`, 2048: mandatory idle cycles after each frame, covering the TX stack's header, CRC and inter-frame gap; ≥ 1.
- `clk`  in  1  `eth_refclk` domain clock.
- `rst`  in  1  Reset: synchronous and active-high.
- `buttons_in`  in  8  Controller state, active-high per button.
- `buttons_valid`  in  1  Single-cycle strobe; `buttons_in` is sampled only when this is high.
- `force_send`  in  1  Requests one frame.
- `tx_enable`  in  1  When low, periodic triggers are suppressed.
- `axiov`  out  1  Payload word valid, wired to `network_stack_tx.axiiv`.
- `axiod`  out  16  Payload word, wired to `network_stack_tx.axiid`.
- `busy`  out  1  High when the state is not IDLE.
- `frames_sent`  out  16  Count of completed frames; wraps at 2^16.

## Operation
- **Button snapshot register (`snap`).** Loaded from `buttons_in` on each `buttons_valid`.
- **Period counter.** Free-running from 0 to PERIOD_CYCLES-1, then wraps. On wrap it sets `per_pend`, but only if `tx_enable` is high.
- **Force request.** `force_send` high sets `frc_pend`.
- **Pending flags.** `per_pend`, `frc_pend` and `chg_pend` are set in any state. They are cleared only when a frame is launched. Any number of triggers before a launch coalesce into one frame.
- **States:**
  - IDLE: if any pending flag is set, copy `snap` into `frame_btn`, clear all pending flags, set word index to 0 and go to SEND.
  - SEND: drive one word per cycle with no stalls (the TX stack has no backpressure).
    - Word 0: `{seq, ~seq}`. Its bytes are never equal, so the vote ignores it.
    - Words 1..PAYLOAD_WORDS-1: `{frame_btn, frame_btn}`.
    - After the last word, `axiov` goes 0. Then `seq` increments (8-bit, wraps), `last_sent` is set to `frame_btn`, `frames_sent` increments, the gap counter loads GAP_CYCLES, and the state goes to GAP.
  - GAP: count down to 0, then go to IDLE.
- **Mid-frame changes.** `snap` updates during SEND do not alter the frame in flight.
- **`tx_enable` deasserted mid-frame.** The current frame completes. An already-set `per_pend` remains set.
- **`axiod` when idle.** Holds 0 whenever `axiov` is 0.

## Timing
- All outputs are registered.
- **Reset values:** `axiov`=0, `axiod`=0, `busy`=0, `frames_sent`=0. Internally: `seq`=0, `snap`=0, `last_sent`=0, pending flags cleared, period counter=0, state=IDLE.
- **Reset mid-frame:** `axiov`=0 on the cycle after the reset edge. The partial frame is abandoned and `frames_sent` is not incremented.
- **Launch latency:** a trigger high in cycle t while in IDLE gives the first `axiov`=1 in cycle t+2.
- **Frame length:** `axiov` is high for exactly PAYLOAD_WORDS consecutive cycles.
- **Frame spacing:** from the last word of one frame to the first `axiov` of the next is at least GAP_CYCLES+2 cycles.
- **`busy`:** rises together with the first `axiov` and falls on the cycle the state returns to IDLE.
- **Same-cycle events:** a trigger arriving in the same cycle as a launch is not lost; it sets its flag for the next frame. The clear from the launch has lower priority than the set.

## Configuration
- Macro: `NES_TX_ON_CHANGE_EN`.
- **Defined:** on a `buttons_valid` cycle where `buttons_in` differs from `last_sent`, set `chg_pend`. Comparison is against `last_sent`, not `snap`, so a press and release that completes within one gap still produces a frame.
- **Undefined:** `chg_pend` does not exist. Frames are sent only on the period and on `force_send`.

## Test plan
Bench parameters: PAYLOAD_WORDS=7, PERIOD_CYCLES=100, GAP_CYCLES=10.

1. Reset, `tx_enable`=1, `buttons_in`=0x81 with `buttons_valid` pulsed -> first frame starts at cycle 101; word0=0x00FF, words 1..6=0x8181; `frames_sent`=1; the next frame's word0=0x01FE.
2. `tx_enable`=0, `force_send` pulse -> `axiov` high 2 cycles later for exactly 7 cycles; then no further frames within 300 cycles.
3. `force_send` pulsed 3 times during one frame's SEND and GAP -> exactly one additional frame; `frames_sent` increases by 2 in total.
4. With `NES_TX_ON_CHANGE_EN` and `tx_enable`=0: `buttons_in` changes 0x00 -> 0x10 -> frame carrying 0x1010. Changing 0x10 -> 0x00 during GAP -> a second frame carrying 0x0000 starts 2 cycles after GAP ends. Without the macro, no frames are sent.
5. Assert `rst` on the 4th word of a frame -> `axiov`=0 on the next cycle; `frames_sent`=0 and `seq`=0 after release; the next frame's word0=0x00FF.
6. Run 256 frames -> `seq` wraps, so the 257th frame's word0=0x00FF; word0 bytes are never equal across all 256 frames.

Source files
------------

// File: rtl/nes_tx_scheduler.sv
// nes_tx_scheduler: latches the local NES controller state and emits fixed-length
// bursts of 16-bit payload words toward network_stack_tx (eth_refclk domain).
// Word 0 is {seq, ~seq}, which never has equal bytes, so the receiver's majority
// vote only counts the {buttons, buttons} words that follow it.
// Optional feature macro: NES_TX_ON_CHANGE_EN -- when defined, a sampled button
// state that differs from the last frame sent also requests a frame.
module nes_tx_scheduler #(
    parameter int PAYLOAD_WORDS = 7,
    parameter int PERIOD_CYCLES = 833_333,
    parameter int GAP_CYCLES    = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  buttons_in,
    input  logic        buttons_valid,
    input  logic        force_send,
    input  logic        tx_enable,
    output logic        axiov,
    output logic [15:0] axiod,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int PER_W = $clog2(PERIOD_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [7:0]       WORD_END = 8'(PAYLOAD_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PER_W-1:0]  perCount_q, perCount_d;
    logic [GAP_W-1:0]  gapCount_q, gapCount_d;
    logic [7:0]        wordIdx_q, wordIdx_d;
    logic [7:0]        snap_q, snap_d;
    logic [7:0]        frameBtn_q, frameBtn_d;
    logic [7:0]        lastSent_q, lastSent_d;
    logic [7:0]        seq_q, seq_d;
    logic [15:0]       framesSent_q, framesSent_d;
    logic              perPend_q, perPend_d;
    logic              frcPend_q, frcPend_d;
    logic              axiov_q, axiov_d;
    logic [15:0]       axiod_q, axiod_d;
    logic              busy_q, busy_d;
    logic              perWrap;
    logic              anyPend;
`ifdef NES_TX_ON_CHANGE_EN
    logic              chgPend_q, chgPend_d;
`endif

    // Next-state logic: trigger bookkeeping, frame sequencing and the registered outputs
    always_comb begin
        state_d      = state_q;
        perWrap      = (perCount_q == PER_LAST);
        perCount_d   = perWrap ? '0 : perCount_q + PER_W'(1);
        gapCount_d   = gapCount_q;
        wordIdx_d    = wordIdx_q;
        snap_d       = buttons_valid ? buttons_in : snap_q;
        frameBtn_d   = frameBtn_q;
        lastSent_d   = lastSent_q;
        seq_d        = seq_q;
        framesSent_d = framesSent_q;
        perPend_d    = perPend_q;
        frcPend_d    = frcPend_q;
        axiov_d      = 1'b0;
        axiod_d      = 16'h0000;
        anyPend      = perPend_q | frcPend_q;
`ifdef NES_TX_ON_CHANGE_EN
        chgPend_d    = chgPend_q;
        anyPend      = anyPend | chgPend_q;
`endif

        case (state_q)
            IDLE: begin
                if (anyPend) begin
                    frameBtn_d = snap_q;
                    perPend_d  = 1'b0;
                    frcPend_d  = 1'b0;
`ifdef NES_TX_ON_CHANGE_EN
                    chgPend_d  = 1'b0;
`endif
                    axiov_d    = 1'b1;
                    axiod_d    = {seq_q, ~seq_q};
                    wordIdx_d  = 8'd1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (wordIdx_q == WORD_END) begin
                    seq_d        = seq_q + 8'd1;
                    lastSent_d   = frameBtn_q;
                    framesSent_d = framesSent_q + 16'd1;
                    gapCount_d   = GAP_LOAD;
                    state_d      = GAP;
                end else begin
                    axiov_d   = 1'b1;
                    axiod_d   = {frameBtn_q, frameBtn_q};
                    wordIdx_d = wordIdx_q + 8'd1;
                end
            end
            GAP: begin
                if (gapCount_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gapCount_d = gapCount_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A trigger in the launch cycle must survive the launch clear.
        if (perWrap && tx_enable) begin
            perPend_d = 1'b1;
        end
        if (force_send) begin
            frcPend_d = 1'b1;
        end
`ifdef NES_TX_ON_CHANGE_EN
        if (buttons_valid && (buttons_in != lastSent_q)) begin
            chgPend_d = 1'b1;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            perCount_q   <= '0;
            gapCount_q   <= '0;
            wordIdx_q    <= 8'd0;
            snap_q       <= 8'd0;
            frameBtn_q   <= 8'd0;
            lastSent_q   <= 8'd0;
            seq_q        <= 8'd0;
            framesSent_q <= 16'd0;
            perPend_q    <= 1'b0;
            frcPend_q    <= 1'b0;
            axiov_q      <= 1'b0;
            axiod_q      <= 16'h0000;
            busy_q       <= 1'b0;
`ifdef NES_TX_ON_CHANGE_EN
            chgPend_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            perCount_q   <= perCount_d;
            gapCount_q   <= gapCount_d;
            wordIdx_q    <= wordIdx_d;
            snap_q       <= snap_d;
            frameBtn_q   <= frameBtn_d;
            lastSent_q   <= lastSent_d;
            seq_q        <= seq_d;
            framesSent_q <= framesSent_d;
            perPend_q    <= perPend_d;
            frcPend_q    <= frcPend_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            busy_q       <= busy_d;
`ifdef NES_TX_ON_CHANGE_EN
            chgPend_q    <= chgPend_d;
`endif
        end
    end

    assign axiov       = axiov_q;
    assign axiod       = axiod_q;
    assign busy        = busy_q;
    assign frames_sent = framesSent_q;

endmodule

// File: tb/tb_nes_tx_scheduler.sv
// tb_nes_tx_scheduler: directed bench for nes_tx_scheduler with
// PAYLOAD_WORDS=7, PERIOD_CYCLES=100, GAP_CYCLES=10.
module tb_nes_tx_scheduler;

    logic        clk;
    logic        rst;
    logic [7:0]  buttonsIn;
    logic        buttonsValid;
    logic        forceSend;
    logic        txEnable;
    logic        axiov;
    logic [15:0] axiod;
    logic        busy;
    logic [15:0] framesSent;

    int          testsRun;
    int          testsFailed;
    int          cycle;

    logic [15:0] frameWords [16];
    int          frameLen;
    int          frameStart;

    typedef struct {
        logic        bv;
        logic [7:0]  btn;
        logic        frc;
        logic        expV;
        logic [15:0] expD;
        logic        expBusy;
        logic [15:0] expFrames;
    } vec_t;

    localparam int NUM_VECS = 29;
    vec_t vecs [NUM_VECS];

    nes_tx_scheduler #(
        .PAYLOAD_WORDS (7),
        .PERIOD_CYCLES (100),
        .GAP_CYCLES    (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttons_in    (buttonsIn),
        .buttons_valid (buttonsValid),
        .force_send    (forceSend),
        .tx_enable     (txEnable),
        .axiov         (axiov),
        .axiod         (axiod),
        .busy          (busy),
        .frames_sent   (framesSent)
    );

    // 100 MHz bench clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs despite the bounded waits
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: advance past the edge so outputs are sampled away from it
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Compare one observed value against its expected value and record the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Synchronous reset; afterwards cycle k is the k-th cycle of the period counter
    task automatic resetDut(input logic txEn);
        rst          = 1'b1;
        buttonsIn    = 8'h00;
        buttonsValid = 1'b0;
        forceSend    = 1'b0;
        txEnable     = txEn;
        step();
        step();
        rst   = 1'b0;
        cycle = 0;
    endtask

    // Wait (bounded) for a frame, then record its words until axiov drops
    task automatic collectFrame(input string name, input int maxWait);
        int waited;
        waited     = 0;
        frameLen   = 0;
        frameStart = -1;
        for (int k = 0; k < 16; k++) frameWords[k] = 16'h0000;
        while (axiov !== 1'b1 && waited < maxWait) begin
            step();
            waited++;
        end
        if (axiov !== 1'b1) begin
            checkOutput({name, "_frame_seen"}, 32'd0, 32'd1);
        end else begin
            frameStart = cycle;
            while (axiov === 1'b1 && frameLen < 16) begin
                frameWords[frameLen] = axiod;
                frameLen++;
                step();
            end
        end
    endtask

    // Count cycles with axiov high over a window where no frame may appear
    task automatic expectQuiet(input string name, input int n);
        int highs;
        highs = 0;
        repeat (n) begin
            step();
            if (axiov === 1'b1) highs++;
        end
        checkOutput(name, highs, 0);
    endtask

    // Pulse force_send for one cycle
    task automatic pulseForce();
        forceSend = 1'b1;
        step();
        forceSend = 1'b0;
    endtask

    // Drive every table vector for one cycle and compare all outputs after the edge
    task automatic applyStimulus();
        for (int i = 0; i < NUM_VECS; i++) begin
            buttonsValid = vecs[i].bv;
            buttonsIn    = vecs[i].btn;
            forceSend    = vecs[i].frc;
            step();
            checkOutput($sformatf("vec%0d_axiov", i), axiov, vecs[i].expV);
            checkOutput($sformatf("vec%0d_axiod", i), axiod, vecs[i].expD);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("vec%0d_frames", i), framesSent, vecs[i].expFrames);
        end
        buttonsValid = 1'b0;
        buttonsIn    = 8'h00;
        forceSend    = 1'b0;
    endtask

    // Force-driven frames with tx_enable low: latency, length, coalescing, mid-frame snapshot
    task automatic fillTable();
        for (int i = 0; i < NUM_VECS; i++) vecs[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0};
        vecs[0].frc = 1'b1;
        vecs[1].expV = 1'b1; vecs[1].expD = 16'h00FF; vecs[1].expBusy = 1'b1;
        for (int i = 2; i <= 7; i++) begin
            vecs[i].expV = 1'b1; vecs[i].expD = 16'h0000; vecs[i].expBusy = 1'b1;
        end
        vecs[4].frc = 1'b1;
        vecs[5].bv  = 1'b1; vecs[5].btn = 8'h55;
        for (int i = 8; i <= 18; i++) begin
            vecs[i].expBusy = 1'b1; vecs[i].expFrames = 16'd1;
        end
        vecs[11].frc = 1'b1;
        vecs[16].frc = 1'b1;
        vecs[19].expFrames = 16'd1;
        vecs[20].expV = 1'b1; vecs[20].expD = 16'h01FE; vecs[20].expBusy = 1'b1; vecs[20].expFrames = 16'd1;
        for (int i = 21; i <= 26; i++) begin
            vecs[i].expV = 1'b1; vecs[i].expD = 16'h5555; vecs[i].expBusy = 1'b1; vecs[i].expFrames = 16'd1;
        end
        for (int i = 27; i <= 28; i++) begin
            vecs[i].expBusy = 1'b1; vecs[i].expFrames = 16'd2;
        end
    endtask

    // Main test sequence
    initial begin
        logic [7:0] firstSeq;
        logic [7:0] s;
        int         waited;
        int         equalBytes;
        int         prevStart;

        testsRun    = 0;
        testsFailed = 0;
        cycle       = 0;
        fillTable();

        // Test 1: periodic frames with the snapshot 0x81
        resetDut(1'b1);
        checkOutput("t1_reset_axiov", axiov, 1'b0);
        checkOutput("t1_reset_frames", framesSent, 16'd0);
        buttonsValid = 1'b1;
        buttonsIn    = 8'h81;
        step();
        buttonsValid = 1'b0;
        buttonsIn    = 8'h00;
`ifdef NES_TX_ON_CHANGE_EN
        collectFrame("t1_chg", 300);
        checkOutput("t1_chg_start", frameStart, 2);
        checkOutput("t1_chg_word0", frameWords[0], 16'h00FF);
        firstSeq = 8'd1;
`else
        firstSeq = 8'd0;
`endif
        collectFrame("t1_per1", 300);
        checkOutput("t1_per1_start", frameStart, 101);
        checkOutput("t1_per1_len", frameLen, 7);
        checkOutput("t1_per1_word0", frameWords[0], {firstSeq, ~firstSeq});
        for (int k = 1; k < 7; k++) checkOutput($sformatf("t1_per1_word%0d", k), frameWords[k], 16'h8181);
        checkOutput("t1_per1_idle_axiod", axiod, 16'h0000);
        checkOutput("t1_frames", framesSent, 32'(firstSeq) + 32'd1);
        collectFrame("t1_per2", 300);
        checkOutput("t1_per2_start", frameStart, 201);
        checkOutput("t1_per2_word0", frameWords[0], {firstSeq + 8'd1, ~(firstSeq + 8'd1)});

        // Tests 2 and 3: table of force-driven cycles, then silence with tx_enable low
        resetDut(1'b0);
        checkOutput("reset_axiov", axiov, 1'b0);
        checkOutput("reset_axiod", axiod, 16'h0000);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frames", framesSent, 16'd0);
        applyStimulus();
        expectQuiet("t2_quiet_300", 300);

        // Test 4: change-triggered frames with tx_enable low
        resetDut(1'b0);
        buttonsValid = 1'b1;
        buttonsIn    = 8'h00;
        step();
        buttonsIn    = 8'h10;
        step();
        buttonsValid = 1'b0;
`ifdef NES_TX_ON_CHANGE_EN
        collectFrame("t4_chg1", 20);
        checkOutput("t4_chg1_start", frameStart, 3);
        checkOutput("t4_chg1_word0", frameWords[0], 16'h00FF);
        checkOutput("t4_chg1_word1", frameWords[1], 16'h1010);
        checkOutput("t4_chg1_word6", frameWords[6], 16'h1010);
        prevStart    = frameStart;
        buttonsValid = 1'b1;
        buttonsIn    = 8'h00;
        step();
        buttonsValid = 1'b0;
        collectFrame("t4_chg2", 40);
        checkOutput("t4_chg2_start", frameStart, prevStart + 19);
        checkOutput("t4_chg2_word0", frameWords[0], 16'h01FE);
        checkOutput("t4_chg2_word3", frameWords[3], 16'h0000);
        checkOutput("t4_frames", framesSent, 16'd2);
`else
        expectQuiet("t4_no_change_frames", 60);
        checkOutput("t4_frames", framesSent, 16'd0);
`endif
        buttonsIn = 8'h00;

        // Same-cycle trigger: a force sampled on the launch edge yields a second frame
        resetDut(1'b0);
        forceSend = 1'b1;
        step();
        step();
        forceSend = 1'b0;
        collectFrame("sc_first", 10);
        checkOutput("sc_first_start", frameStart, 2);
        prevStart = frameStart;
        collectFrame("sc_second", 40);
        checkOutput("sc_second_start", frameStart, prevStart + 19);
        checkOutput("sc_second_word0", frameWords[0], 16'h01FE);

        // Test 5: reset during the fourth word of a frame
        resetDut(1'b0);
        pulseForce();
        collectFrame("t5_first", 10);
        checkOutput("t5_first_word0", frameWords[0], 16'h00FF);
        pulseForce();
        waited = 0;
        while (axiov !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        checkOutput("t5_second_word0", axiod, 16'h01FE);
        step();
        step();
        step();
        checkOutput("t5_word3_valid", axiov, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t5_after_rst_axiov", axiov, 1'b0);
        checkOutput("t5_after_rst_busy", busy, 1'b0);
        checkOutput("t5_after_rst_frames", framesSent, 16'd0);
        pulseForce();
        collectFrame("t5_third", 10);
        checkOutput("t5_third_word0", frameWords[0], 16'h00FF);
        checkOutput("t5_third_len", frameLen, 7);
        checkOutput("t5_frames", framesSent, 16'd1);

        // Test 6: 257 back-to-back frames; the sequence byte wraps after 256
        resetDut(1'b0);
        forceSend  = 1'b1;
        equalBytes = 0;
        prevStart  = 0;
        for (int i = 0; i < 257; i++) begin
            collectFrame($sformatf("t6_f%0d", i), 40);
            if (i == 1) checkOutput("t6_spacing", frameStart - prevStart, 19);
            prevStart = frameStart;
            if (i < 256) begin
                s = i[7:0];
                checkOutput($sformatf("t6_f%0d_word0", i), frameWords[0], {s, ~s});
                if (frameWords[0][15:8] == frameWords[0][7:0]) equalBytes++;
            end else begin
                checkOutput("t6_wrap_word0", frameWords[0], 16'h00FF);
            end
        end
        forceSend = 1'b0;
        checkOutput("t6_equal_byte_words", equalBytes, 0);
        checkOutput("t6_frames", framesSent, 16'd257);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
